// File: rtl/delta_sigma_dac.sv
`default_nettype none
// ============================================================================
// Module      : delta_sigma_dac
// Description : Linear-interpolating first-order delta-sigma DAC. Each strobed
//               sample is ramped over 2^LF clocks and modulated to a 1-bit stream.
// Revision    : 1.0 - initial release
// ============================================================================
module delta_sigma_dac #(
    parameter int DW = 10,
    parameter int LF = 10   // must be >= 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_dac_dt,
    input  logic          i_dac_dt_en,
    output logic          o_dac,
    output logic          o_hold,
    output logic          o_early
);

    localparam int            c_N        = DW + LF;
    localparam logic [LF-1:0] c_CNT_LAST = {LF{1'b1}};
    localparam logic [LF-1:0] c_CNT_ONE  = {{(LF-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_tgt;
    logic [c_N-1:0]  r_interp;
    logic [DW:0]     r_step;
    logic [LF-1:0]   r_cnt;
    logic [c_N-1:0]  r_acc;

    logic [c_N-1:0]  w_step_ext;
    logic [c_N:0]    w_sum;
    logic            w_last;

    // Step is a signed DW+1 difference; sign-extend it onto the interpolant width
    assign w_step_ext = {{(LF-1){r_step[DW]}}, r_step};
    assign w_last     = (r_cnt == c_CNT_LAST);
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_interp};
    assign o_hold     = (r_state == S_IDLE);

    // Ramp control: a new strobe always restarts from the last accepted target
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_tgt    <= '0;
            r_interp <= '0;
            r_step   <= '0;
            r_cnt    <= '0;
            o_early  <= 1'b0;
        end else if (i_dac_dt_en) begin
            r_tgt    <= i_dac_dt;
            r_interp <= {r_tgt, {LF{1'b0}}};
            r_step   <= {1'b0, i_dac_dt} - {1'b0, r_tgt};
            r_cnt    <= '0;
            r_state  <= S_RAMP;
            o_early  <= (r_state == S_RAMP) && !w_last;
        end else begin
            o_early <= 1'b0;
            if (r_state == S_RAMP) begin
                r_interp <= r_interp + w_step_ext;
                r_cnt    <= r_cnt + c_CNT_ONE;
                if (w_last) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    // First-order modulator: the carry out of the accumulator is the bitstream
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            o_dac <= 1'b0;
        end else begin
            r_acc <= w_sum[c_N-1:0];
            o_dac <= w_sum[c_N];
        end
    end

endmodule
`default_nettype wire
